// File: rtl/trig_chk_pkg.sv
// Shared constants and types for the L1A/LCT trigger-stream checker.
//   DEF_*        default parameter values for the checker
//   DEF_CNT_W    counter width
//   LCT_W        LCT bus width; bit 0 is OR-of-chambers
//   CH_HI:CH_LO  per-chamber bit range of the LCT bus
package trig_chk_pkg;
  localparam int DEF_MATCH_DLY = 4;
  localparam int DEF_WIN       = 3;
  localparam int DEF_MIN_GAP   = 3;
  localparam int DEF_RULE2_WIN = 24;
  localparam int DEF_CNT_W     = 16;

  localparam int LCT_W   = 6;
  localparam int CH_HI   = 5;
  localparam int CH_LO   = 1;
  localparam int NUM_CNT = 4;

  typedef logic [LCT_W-1:0] lct_t;

  // counter slots in the saturating counter array
  typedef enum logic [1:0] {
    CNT_L1A    = 2'd0,
    CNT_MATCH  = 2'd1,
    CNT_ORPHAN = 2'd2,
    CNT_RULE   = 2'd3
  } cnt_idx_e;

  // per-cycle events decided from the registered inputs
  typedef struct packed {
    logic match;
    logic nomatch;
    logic orphan;
    logic gap;
    logic rule2;
  } evt_t;
endpackage

// File: rtl/l1a_lct_checker_sat_cnt.sv
// Saturating up-counter with synchronous clear.
//   CLK, RST_N  clock, async active-low reset
//   CLR         synchronous clear, wins over INC
//   INC         increment request; ignored once Q is all-ones
//   Q           count
module sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             INC,
  output logic [CNT_W-1:0] Q
);
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)            Q <= '0;
    else if (CLR)          Q <= '0;
    else if (INC && !(&Q)) Q <= Q + CNT_W'(1);
  end
endmodule

// File: rtl/l1a_lct_checker.sv
// Receive-side checker pairing each L1A with the LCTs that precede it by
// MATCH_DLY..MATCH_DLY+WIN-1 cycles. Flags unmatched L1As, unclaimed LCTs,
// L1A spacing (MIN_GAP) and rule-2 (max 2 L1As per RULE2_WIN) violations.
//   CLK, RST_N      clock, async active-low reset
//   EN              checking enable; low shifts zeros into the histories
//   CLR             sync clear of counters and sticky flags
//   L1A, LCT        trigger inputs (LCT[0] = OR of chambers)
//   L1A_MATCH/NOMATCH, LCT_ORPHAN   1-cycle event pulses
//   MATCH_BITS      per-chamber OR of the last L1A window, held
//   GAP_ERR, RULE2_ERR              sticky flags
//   *_CNT           saturating event counters
// All inputs are registered first, so every output lands one edge after the
// edge its inputs were sampled on; ages below are relative to that sample.
// Assumes MATCH_DLY >= 1, WIN >= 1, RULE2_WIN >= 3.
module l1a_lct_checker
  import trig_chk_pkg::*;
#(
  parameter int MATCH_DLY = DEF_MATCH_DLY,
  parameter int WIN       = DEF_WIN,
  parameter int MIN_GAP   = DEF_MIN_GAP,
  parameter int RULE2_WIN = DEF_RULE2_WIN,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   EN,
  input  logic                   CLR,
  input  logic                   L1A,
  input  logic [LCT_W-1:0]       LCT,
  output logic                   L1A_MATCH,
  output logic                   L1A_NOMATCH,
  output logic [CH_HI-CH_LO:0]   MATCH_BITS,
  output logic                   LCT_ORPHAN,
  output logic                   GAP_ERR,
  output logic                   RULE2_ERR,
  output logic [CNT_W-1:0]       L1A_CNT,
  output logic [CNT_W-1:0]       MATCH_CNT,
  output logic [CNT_W-1:0]       ORPHAN_CNT,
  output logic [CNT_W-1:0]       RULE_ERR_CNT
);
  localparam int DEPTH   = MATCH_DLY + WIN;
  localparam int R2_PREV = RULE2_WIN - 1;
  localparam int R2C_W   = $clog2(RULE2_WIN + 1);
  localparam int GAP_W   = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);

  // hist_q[d] holds the LCT of age d; hist_q[0] doubles as the input register
  lct_t                 hist_q [DEPTH];
  lct_t                 hist_d [DEPTH];
  logic                 l1a_q, en_q, clr_q;
  logic [R2_PREV-1:0]   r2_q, r2_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  lct_t                 win_or;
  logic [R2C_W-1:0]     r2_ones;
  evt_t                 evt;
  logic                 gap_err_d, r2_err_d;
  logic [CH_HI-CH_LO:0] match_bits_d;

  always_comb begin
    win_or = '0;
    for (int k = MATCH_DLY; k < DEPTH; k++) win_or = win_or | hist_q[k];

    // shift one age; an L1A consumes its whole window on the same update
    hist_d[0] = EN ? LCT : '0;
    for (int k = 1; k < DEPTH; k++)
      hist_d[k] = (l1a_q && (k - 1) >= MATCH_DLY) ? '0 : hist_q[k-1];

    r2_ones = '0;
    for (int i = 0; i < R2_PREV; i++) r2_ones = r2_ones + R2C_W'(r2_q[i]);

    // l1a_q is already EN-gated at the input register
    evt.match   = l1a_q &  win_or[0];
    evt.nomatch = l1a_q & ~win_or[0];
    // the oldest entry is always inside the window, so any L1A claims it
    evt.orphan  = en_q & hist_q[DEPTH-1][0] & ~l1a_q;
    evt.gap     = l1a_q & (gap_q != '0);
    evt.rule2   = l1a_q & (r2_ones >= R2C_W'(2));

    if (l1a_q)              gap_d = GAP_LOAD;
    else if (gap_q != '0)   gap_d = gap_q - GAP_W'(1);
    else                    gap_d = gap_q;

    r2_d = {r2_q[R2_PREV-2:0], l1a_q};

    gap_err_d    = clr_q ? 1'b0 : (GAP_ERR   | evt.gap);
    r2_err_d     = clr_q ? 1'b0 : (RULE2_ERR | evt.rule2);
    match_bits_d = l1a_q ? win_or[CH_HI:CH_LO] : MATCH_BITS;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < DEPTH; k++) hist_q[k] <= '0;
      l1a_q       <= 1'b0;
      en_q        <= 1'b0;
      clr_q       <= 1'b0;
      r2_q        <= '0;
      gap_q       <= '0;
      L1A_MATCH   <= 1'b0;
      L1A_NOMATCH <= 1'b0;
      LCT_ORPHAN  <= 1'b0;
      MATCH_BITS  <= '0;
      GAP_ERR     <= 1'b0;
      RULE2_ERR   <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      l1a_q       <= EN & L1A;
      en_q        <= EN;
      clr_q       <= CLR;
      r2_q        <= r2_d;
      gap_q       <= gap_d;
      L1A_MATCH   <= evt.match;
      L1A_NOMATCH <= evt.nomatch;
      LCT_ORPHAN  <= evt.orphan;
      MATCH_BITS  <= match_bits_d;
      GAP_ERR     <= gap_err_d;
      RULE2_ERR   <= r2_err_d;
    end
  end

  logic [NUM_CNT-1:0]            cnt_inc;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_q;

  assign cnt_inc[CNT_L1A]    = l1a_q;
  assign cnt_inc[CNT_MATCH]  = evt.match;
  assign cnt_inc[CNT_ORPHAN] = evt.orphan;
  assign cnt_inc[CNT_RULE]   = evt.gap | evt.rule2;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .CLK   (CLK),
      .RST_N (RST_N),
      .CLR   (clr_q),
      .INC   (cnt_inc[g]),
      .Q     (cnt_q[g])
    );
  end

  assign L1A_CNT      = cnt_q[CNT_L1A];
  assign MATCH_CNT    = cnt_q[CNT_MATCH];
  assign ORPHAN_CNT   = cnt_q[CNT_ORPHAN];
  assign RULE_ERR_CNT = cnt_q[CNT_RULE];
endmodule

// File: doc/l1a_lct_checker.md
# l1a_lct_checker

Receive-side checker for the random trigger stream. It consumes the L1A pulse and the 6-bit LCT bus and pairs each L1A with the LCTs that precede it by a fixed latency. It flags L1As with no LCT and LCTs that are never claimed by an L1A, and enforces the L1A spacing and rule-2 constraints. It sits on the DMB test path and exposes event pulses, sticky error flags and saturating counters for JTAG readout.

## Interface
Parameters:
- MATCH_DLY, 4: cycles from LCT to its L1A (minimum age searched).
- WIN, 3: match window width in cycles; 1..8.
- MIN_GAP, 3: minimum L1A-to-L1A distance in cycles.
- RULE2_WIN, 24: sliding window length; at most 2 L1As are allowed in any RULE2_WIN consecutive cycles.
- CNT_W, 16: counter width.

Ports (all synchronous to CLK except RST_N):
- CLK, input, 1: single clock. Everything is posedge.
- RST_N, input, 1: reset, asynchronous, active-low.
- EN, input, 1: checking enable. When low, history shifts in zeros and no events, flags or counts are produced.
- CLR, input, 1: synchronous clear of counters and sticky flags.
- L1A, input, 1: L1A pulse, one cycle per trigger.
- LCT, input, 6: bit 0 is OR-of-chambers; bits 5:1 are per-chamber.
- L1A_MATCH, output, 1: pulse when an L1A found an LCT[0] in its window.
- L1A_NOMATCH, output, 1: pulse when an L1A found no LCT[0] in its window.
- MATCH_BITS, output, 5: per-chamber OR over the window. Updated on each L1A and held until the next L1A.
- LCT_ORPHAN, output, 1: pulse when an LCT[0] ages out unclaimed.
- GAP_ERR, output, 1: sticky; set when an L1A arrives closer than MIN_GAP to the previous one.
- RULE2_ERR, output, 1: sticky; set when a 3rd L1A arrives within RULE2_WIN.
- L1A_CNT, output, CNT_W: count of L1As.
- MATCH_CNT, output, CNT_W: count of L1A_MATCH events.
- ORPHAN_CNT, output, CNT_W: count of LCT_ORPHAN events.
- RULE_ERR_CNT, output, CNT_W: count of GAP or rule-2 violation events; both on one L1A counts 1.

## Operation
- LCT history is a 6 x (MATCH_DLY+WIN) shift register. An LCT sampled on edge t has age d at edge t+d.
- On an L1A sampled at edge t, with EN high:
  - The window is ages MATCH_DLY .. MATCH_DLY+WIN-1, with ages measured at edge t.
  - MATCHED is the OR of LCT[0] over the window.
  - MATCH_BITS is the OR of LCT[5:1] over the window.
  - All window entries, all 6 bits, are cleared (consumed) in the same update, so no LCT can match two L1As.
- Orphan: an LCT[0] that reaches age MATCH_DLY+WIN-1 and is not consumed on that edge produces LCT_ORPHAN.
  - If an L1A consumes that same entry on that edge, there is no orphan; consumption wins.
- Gap check:
  - A down-counter is loaded with MIN_GAP-1 on each L1A and saturates at 0.
  - An L1A while the counter is nonzero sets GAP_ERR.
- Rule 2:
  - A RULE2_WIN-bit L1A history shift register is kept.
  - If the current L1A plus the number of ones in the previous RULE2_WIN-1 cycles is 3 or more, RULE2_ERR is set.
- Counters saturate at all-ones and do not wrap.
- CLR zeroes the 4 counters, GAP_ERR and RULE2_ERR. CLR has priority over a same-cycle increment, which is lost.
  - CLR does not touch the LCT or L1A history.
- Reset (RST_N low, at any time):
  - All outputs, counters, flags, MATCH_BITS and histories go to 0.
  - The gap counter goes to 0.
  - Operation resumes at the first edge after release with empty history.
- EN falling mid-stream: history continues to shift but loads zeros. In-flight LCTs still age out and may raise LCT_ORPHAN only while EN is high.

## Timing
- Latency: L1A at edge t gives L1A_MATCH / L1A_NOMATCH / MATCH_BITS registered at edge t+1.
  - The L1A_CNT, MATCH_CNT and RULE_ERR_CNT increments and the flag sets also occur at edge t+1.
- An LCT sampled at edge t that is orphaned gives LCT_ORPHAN at edge t+MATCH_DLY+WIN; ORPHAN_CNT increments on the same edge.
- All pulses are exactly 1 cycle wide. There are no combinational input-to-output paths.

## Structure
- Shared package trig_chk_pkg holds:
  - default parameter constants;
  - CNT_W;
  - the LCT bus width (6);
  - the per-chamber index range 5:1.
- One sub-module sat_cnt (CNT_W, CLK, RST_N, CLR, INC, Q), instantiated 4 times.
- Histories, window logic and rule checks live in the top level.

## Test plan
All scenarios use default parameters.
1. LCT=6'b001001 at edge 10, L1A at edge 14 -> at edge 15: L1A_MATCH=1, MATCH_BITS=5'b00100, MATCH_CNT=1, L1A_CNT=1; no LCT_ORPHAN at edge 17.
2. L1A at edge 20 with no LCT -> L1A_NOMATCH at edge 21; L1A_CNT=1, MATCH_CNT=0.
3. LCT=6'b000011 at edge 30, no L1A -> LCT_ORPHAN at edge 37 only, ORPHAN_CNT=1. Repeat with LCT at edges 30,31,32 and L1A at edge 36 -> all three consumed, one match, zero orphans.
4. L1As at edges 40 and 42 -> GAP_ERR=1 at edge 43, RULE_ERR_CNT=1. After CLR, L1As at 50, 53, 56 -> RULE2_ERR=1 at edge 57, GAP_ERR=0. L1As at 100 and 124 -> no error.
5. CLR and L1A together at edge 60 with L1A_CNT=5 -> L1A_CNT=0 at edge 61. Hold ORPHAN_CNT incrementing past 65535 -> stays 16'hFFFF.
6. RST_N pulsed low for 1 cycle between LCT at edge 70 and L1A at edge 74 -> all outputs 0 during reset; L1A at 74 gives L1A_NOMATCH; no orphan from the pre-reset LCT.
